// File: rtl/stim_pkg.sv
// Shared types, 4-ASK levels and PRBS15 helpers for the 4-ASK stimulus source.
package stim_pkg;

    localparam int PRBS_W      = 15;
    localparam int PRBS_TAP_HI = 14;
    localparam int PRBS_TAP_LO = 13;

    typedef logic signed [17:0] sample_t;

    localparam sample_t LVL_P3 =  18'sd98304;
    localparam sample_t LVL_P1 =  18'sd32768;
    localparam sample_t LVL_M1 = -18'sd32768;
    localparam sample_t LVL_M3 = -18'sd98304;

    // Gray-coded symbol to 1s17 amplitude level.
    function automatic sample_t map_ask4(input logic [1:0] sym);
        sample_t lvl;
        case (sym)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b11:   lvl = LVL_P1;
            2'b10:   lvl = LVL_P3;
            default: lvl = 18'sd0;
        endcase
        return lvl;
    endfunction

    // One Fibonacci step of x^15+x^14+1; the new bit enters at bit 0.
    function automatic logic [PRBS_W-1:0] prbs_step(input logic [PRBS_W-1:0] s);
        return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs15_2step.sv
// PRBS15 register that advances two steps per symbol and presents the next
// 2-bit symbol combinationally from the current state.
module prbs15_2step
    import stim_pkg::*;
#(
    parameter logic [PRBS_W-1:0] SEED = 15'h0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_adv,
    output logic [1:0] o_sym
);

    logic [PRBS_W-1:0] r_lfsr;
    logic [PRBS_W-1:0] w_step1;
    logic [PRBS_W-1:0] w_step2;

    // Two chained steps; the symbol is {first new bit, second new bit}.
    always_comb begin
        w_step1 = prbs_step(r_lfsr);
        w_step2 = prbs_step(w_step1);
        o_sym   = {w_step1[0], w_step2[0]};
    end

    // LFSR state; an all-zero state would lock up, so it is forced back to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (r_lfsr == {PRBS_W{1'b0}}) begin
            r_lfsr <= 15'h0001;
        end else if (i_adv) begin
            r_lfsr <= w_step2;
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

endmodule

// File: rtl/ask4_stim_src.sv
// PRBS-driven 4-ASK symbol source upsampled by N_SPS for the sine_filt input.
// Optional macro STIM_HOLD_EN: sample-and-hold upsampling instead of zero-stuffing.
module ask4_stim_src
    import stim_pkg::*;
#(
    parameter int                N_SPS = 4,
    parameter logic [PRBS_W-1:0] SEED  = 15'h0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output sample_t    x_out,
    output logic       sym_strobe,
    output logic [1:0] sym_bits
);

    localparam int PW = (N_SPS > 1) ? $clog2(N_SPS) : 1;

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_nxt;
    logic          w_sym_start;
    logic          w_adv;
    logic [1:0]    w_sym;
    sample_t       w_fill;
    sample_t       r_x;
    logic          r_strobe;
    logic [1:0]    r_sym_bits;

    prbs15_2step #(
        .SEED (SEED)
    ) u_prbs (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_adv),
        .o_sym (w_sym)
    );

    // Phase wrap, symbol-start decode and the between-symbol fill value.
    always_comb begin
        w_phase_nxt = r_phase + PW'(1);
        if (r_phase == PW'(N_SPS - 1)) begin
            w_phase_nxt = {PW{1'b0}};
        end else begin
            w_phase_nxt = r_phase + PW'(1);
        end
        w_sym_start = (r_phase == {PW{1'b0}});
        w_adv       = en & w_sym_start;
`ifdef STIM_HOLD_EN
        w_fill      = map_ask4(r_sym_bits);
`else
        w_fill      = 18'sd0;
`endif
    end

    // Phase counter and output registers; en=0 freezes everything but the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= {PW{1'b0}};
            r_x        <= 18'sd0;
            r_strobe   <= 1'b0;
            r_sym_bits <= 2'b00;
        end else if (en) begin
            r_phase <= w_phase_nxt;
            if (w_sym_start) begin
                r_x        <= map_ask4(w_sym);
                r_strobe   <= 1'b1;
                r_sym_bits <= w_sym;
            end else begin
                r_x        <= w_fill;
                r_strobe   <= 1'b0;
                r_sym_bits <= r_sym_bits;
            end
        end else begin
            r_phase    <= r_phase;
            r_x        <= r_x;
            r_strobe   <= 1'b0;
            r_sym_bits <= r_sym_bits;
        end
    end

    assign x_out      = r_x;
    assign sym_strobe = r_strobe;
    assign sym_bits   = r_sym_bits;

endmodule

// File: tb/tb_ask4_stim_src.sv
// Self-checking bench for ask4_stim_src: table vectors, corner sequences and a
// bit-stream reference model run against instances with N_SPS = 4, 2 and 16.
module tb_ask4_stim_src;

`ifdef STIM_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam int MEM = 65600;

    logic clk;
    logic rst [3];
    logic en  [3];
    logic signed [17:0] x0, x1, x2;
    logic s0, s1, s2;
    logic [1:0] b0, b1, b2;

    int checks = 0;
    int errors = 0;

    ask4_stim_src #(.N_SPS(4),  .SEED(15'h0001)) dut  (.clk(clk), .reset(rst[0]), .en(en[0]),
        .x_out(x0), .sym_strobe(s0), .sym_bits(b0));
    ask4_stim_src #(.N_SPS(2),  .SEED(15'h0001)) dut2 (.clk(clk), .reset(rst[1]), .en(en[1]),
        .x_out(x1), .sym_strobe(s1), .sym_bits(b1));
    ask4_stim_src #(.N_SPS(16), .SEED(15'h0001)) dut16 (.clk(clk), .reset(rst[2]), .en(en[2]),
        .x_out(x2), .sym_strobe(s2), .sym_bits(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PRBS as a bit stream s[n] = s[n-15] ^ s[n-14].
    int        nsps [3] = '{4, 2, 16};
    bit        m_s  [3][MEM];
    int        m_nbits [3];
    int        m_k  [3];
    int        m_x  [3];
    bit        m_strb [3];
    bit [1:0]  m_bits [3];

    function automatic int level(input bit [1:0] g);
        int idx;
        idx = (g == 2'b00) ? 0 : (g == 2'b01) ? 1 : (g == 2'b11) ? 2 : 3;
        return (2 * idx - 3) * 32768;
    endfunction

    task automatic model_reset(input int id);
        bit [14:0] seed;
        seed = 15'h0001;
        for (int i = 0; i < 15; i++) m_s[id][14 - i] = seed[i];
        m_nbits[id] = 15;
        m_k[id] = 0;
        m_x[id] = 0;
        m_strb[id] = 1'b0;
        m_bits[id] = 2'b00;
    endtask

    task automatic model_step(input int id, input bit r, input bit e);
        int n;
        bit c1, c2;
        if (r) begin
            model_reset(id);
        end else if (e) begin
            if (m_k[id] % nsps[id] == 0) begin
                n = m_nbits[id];
                c1 = m_s[id][n - 15] ^ m_s[id][n - 14];
                m_s[id][n] = c1;
                c2 = m_s[id][n - 14] ^ m_s[id][n - 13];
                m_s[id][n + 1] = c2;
                m_nbits[id] = n + 2;
                m_bits[id] = {c1, c2};
                m_x[id] = level({c1, c2});
                m_strb[id] = 1'b1;
            end else begin
                m_x[id] = HOLD ? level(m_bits[id]) : 0;
                m_strb[id] = 1'b0;
            end
            m_k[id]++;
        end else begin
            m_strb[id] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int get_x(input int id);
        return (id == 0) ? int'(x0) : (id == 1) ? int'(x1) : int'(x2);
    endfunction
    function automatic int get_s(input int id);
        return (id == 0) ? int'(s0) : (id == 1) ? int'(s1) : int'(s2);
    endfunction
    function automatic int get_b(input int id);
        return (id == 0) ? int'(b0) : (id == 1) ? int'(b1) : int'(b2);
    endfunction

    task automatic check_model(input int id);
        chk($sformatf("model_x[%0d]", id), get_x(id), m_x[id]);
        chk($sformatf("model_strobe[%0d]", id), get_s(id), int'(m_strb[id]));
        chk($sformatf("model_bits[%0d]", id), get_b(id), int'(m_bits[id]));
    endtask

    // One clock: model sees the inputs present at the edge; sample #1 later.
    task automatic tick();
        @(posedge clk);
        for (int id = 0; id < 3; id++) model_step(id, rst[id], en[id]);
        #1;
    endtask

    typedef struct {
        bit       r;
        bit       e;
        int       x;
        bit       strb;
        bit [1:0] bits;
    } vec_t;

    vec_t vecs [30];
    int   cnt [4];
    int   nstr, last_str2, last_str16, cyc;

    initial begin
        for (int id = 0; id < 3; id++) begin
            rst[id] = 1'b1;
            en[id]  = 1'b0;
            model_reset(id);
        end

        // Table: reset with en=1, 28 enabled samples, then one en=0 cycle.
        vecs[0] = '{r: 1'b1, e: 1'b1, x: 0, strb: 1'b0, bits: 2'b00};
        for (int i = 1; i < 29; i++) begin
            int k, j, lvl;
            k = i - 1;
            j = k / 4;
            lvl = (j < 6) ? -98304 : -32768;
            vecs[i].r = 1'b0;
            vecs[i].e = 1'b1;
            vecs[i].strb = (k % 4 == 0);
            vecs[i].x = (k % 4 == 0) ? lvl : (HOLD ? lvl : 0);
            vecs[i].bits = (j < 6) ? 2'b00 : 2'b01;
        end
        vecs[29] = '{r: 1'b0, e: 1'b0, x: (HOLD ? -32768 : 0), strb: 1'b0, bits: 2'b01};

        tick();
        for (int i = 0; i < 30; i++) begin
            rst[0] = vecs[i].r;
            en[0]  = vecs[i].e;
            tick();
            chk($sformatf("tbl_x[%0d]", i), int'(x0), vecs[i].x);
            chk($sformatf("tbl_strobe[%0d]", i), int'(s0), int'(vecs[i].strb));
            chk($sformatf("tbl_bits[%0d]", i), int'(b0), int'(vecs[i].bits));
        end

        // en toggled 1,0,0,1 mid-symbol against the gapless model.
        rst[0] = 1'b1; en[0] = 1'b0; tick();
        rst[0] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            en[0] = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            tick();
            check_model(0);
            if (i == 3 || i == 4) chk("gap_strobe", int'(s0), 0);
        end

        // Reset for one cycle at phase 2.
        rst[0] = 1'b1; en[0] = 1'b1; tick();
        rst[0] = 1'b0; tick(); tick();
        rst[0] = 1'b1; tick();
        chk("midrst_x", int'(x0), 0);
        chk("midrst_strobe", int'(s0), 0);
        rst[0] = 1'b0; tick();
        chk("restart_x", int'(x0), -98304);
        chk("restart_strobe", int'(s0), 1);
        chk("restart_bits", int'(b0), 0);

        // Randomized enable and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            en[0]  = ($urandom_range(0, 3) != 0);
            rst[0] = ($urandom_range(0, 199) == 0);
            tick();
            check_model(0);
        end

        // Full PRBS period on N_SPS=2 with N_SPS=16 alongside.
        rst[0] = 1'b1; en[0] = 1'b0;
        rst[1] = 1'b1; rst[2] = 1'b1; tick();
        rst[1] = 1'b0; rst[2] = 1'b0; en[1] = 1'b1; en[2] = 1'b1;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        nstr = 0; last_str2 = -1; last_str16 = -1; cyc = 0;
        while (nstr < 32767 && cyc < 70000) begin
            tick();
            check_model(1);
            check_model(2);
            if (s1) begin
                if (last_str2 >= 0) chk("period2", cyc - last_str2, 2);
                last_str2 = cyc;
                cnt[b1]++;
                nstr++;
            end
            if (s2) begin
                if (last_str16 >= 0) chk("period16", cyc - last_str16, 16);
                last_str16 = cyc;
            end
            cyc++;
        end
        chk("period_symbols", nstr, 32767);
        chk("lfsr_wrap", int'(dut2.u_prbs.r_lfsr), 1);
        chk("cnt00_in_range", int'(cnt[0] >= 8190 && cnt[0] <= 8192), 1);
        chk("cnt01_in_range", int'(cnt[1] >= 8191 && cnt[1] <= 8193), 1);
        chk("cnt11_in_range", int'(cnt[3] >= 8191 && cnt[3] <= 8193), 1);
        chk("cnt10_in_range", int'(cnt[2] >= 8191 && cnt[2] <= 8193), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
